// File: rtl/frame_char_reader.sv
// ---------------------------------------------------------------------------
// frame_char_reader
//
// Purpose:
//   Read-side consumer of the display-frame bundle (18 BCD digits, AM_PM,
//   dia_semana, funcion, cursor_location). The whole bundle is captured once
//   per video frame on frame_tick so the picture never shows a half-updated
//   value, and the captured copy is served to the VGA text renderer as ASCII
//   codes plus a blinking cursor-highlight flag through a request/response
//   port with one cycle of latency.
//
// Ports:
//   clk                     system clock
//   reset                   asynchronous assert, synchronous release, active low
//   digit1_* / digit0_*     BCD tens / units of time, date and timer fields
//   AM_PM                   0 = AM, 1 = PM
//   dia_semana              0 = LUN .. 6 = DOM, 7 = invalid (shown as "---")
//   funcion                 00 normal, 01 cfg time, 10 cfg date, 11 cfg timer
//   cursor_location         field under edit: 10 left, 01 middle, 00 right
//   frame_tick              one-cycle pulse at the start of vertical blank
//   char_req / char_idx     character request strobe and slot number
//   char_valid              response strobe, one cycle after char_req
//   char_code               7-bit ASCII code of the requested slot
//   char_hl                 slot is part of the highlighted (blinking) field
//
// Screen line layout (slot numbers):
//   0-1 HH  2 ':'  3-4 MM  5 ':'  6-7 SS  8 ' '  9-10 AM/PM  11 ' '
//   12-13 DAY  14 '/'  15-16 MES  17 '/'  18-19 YEAR  20 ' '  21-23 day name
//   24 ' '  25-26 HH_T  27 ':'  28-29 MM_T  30 ':'  31-32 SS_T
//   anything above 32 is a blank.
// ---------------------------------------------------------------------------
module frame_char_reader #(
  parameter int BLINK_FRAMES = 30,
  parameter int IDX_W        = 6
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [3:0]       digit0_HH,
  input  logic [3:0]       digit1_HH,
  input  logic [3:0]       digit0_MM,
  input  logic [3:0]       digit1_MM,
  input  logic [3:0]       digit0_SS,
  input  logic [3:0]       digit1_SS,

  input  logic [3:0]       digit0_DAY,
  input  logic [3:0]       digit1_DAY,
  input  logic [3:0]       digit0_MES,
  input  logic [3:0]       digit1_MES,
  input  logic [3:0]       digit0_YEAR,
  input  logic [3:0]       digit1_YEAR,

  input  logic [3:0]       digit0_HH_T,
  input  logic [3:0]       digit1_HH_T,
  input  logic [3:0]       digit0_MM_T,
  input  logic [3:0]       digit1_MM_T,
  input  logic [3:0]       digit0_SS_T,
  input  logic [3:0]       digit1_SS_T,

  input  logic             AM_PM,
  input  logic [2:0]       dia_semana,
  input  logic [1:0]       funcion,
  input  logic [1:0]       cursor_location,

  input  logic             frame_tick,
  input  logic             char_req,
  input  logic [IDX_W-1:0] char_idx,

  output logic             char_valid,
  output logic [6:0]       char_code,
  output logic             char_hl
);

  // Width of the blink frame counter; a single bit is enough when every
  // frame toggles the cursor.
  localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_COLON = 7'h3A;
  localparam logic [6:0] CH_SLASH = 7'h2F;
  localparam logic [6:0] CH_QUEST = 7'h3F;

  // Digits are kept in screen order (tens before units) so the slot decoder
  // can address them as one list:
  //   0-1 HH, 2-3 MM, 4-5 SS, 6-7 DAY, 8-9 MES, 10-11 YEAR,
  //   12-13 HH_T, 14-15 MM_T, 16-17 SS_T
  logic [3:0] live_dig [18];
  logic [3:0] snap_dig [18];

  logic       snap_ampm;
  logic [2:0] snap_dia;
  logic [1:0] snap_fun;
  logic [1:0] snap_cur;

  logic [CNT_W-1:0] frame_cnt;
  logic             blink_on;

  logic [5:0] slot;
  logic       in_range;
  logic [6:0] slot_code;
  logic       slot_hl;
  logic [20:0] day_chars;

  logic [5:0] group_base;
  logic [5:0] pair_off;
  logic [5:0] hl_first;
  logic       hl_enable;

  assign live_dig[0]  = digit1_HH;
  assign live_dig[1]  = digit0_HH;
  assign live_dig[2]  = digit1_MM;
  assign live_dig[3]  = digit0_MM;
  assign live_dig[4]  = digit1_SS;
  assign live_dig[5]  = digit0_SS;
  assign live_dig[6]  = digit1_DAY;
  assign live_dig[7]  = digit0_DAY;
  assign live_dig[8]  = digit1_MES;
  assign live_dig[9]  = digit0_MES;
  assign live_dig[10] = digit1_YEAR;
  assign live_dig[11] = digit0_YEAR;
  assign live_dig[12] = digit1_HH_T;
  assign live_dig[13] = digit0_HH_T;
  assign live_dig[14] = digit1_MM_T;
  assign live_dig[15] = digit0_MM_T;
  assign live_dig[16] = digit1_SS_T;
  assign live_dig[17] = digit0_SS_T;

  // BCD digit to ASCII; codes above 9 cannot be shown as a digit.
  function automatic logic [6:0] bcd_char(input logic [3:0] d);
    if (d > 4'd9) begin
      return CH_QUEST;
    end
    return 7'h30 + {3'b000, d};
  endfunction

  // Three-letter Spanish weekday name, first letter in the top bits.
  function automatic logic [20:0] day_name(input logic [2:0] d);
    case (d)
      3'd0:    return {7'h4C, 7'h55, 7'h4E};  // LUN
      3'd1:    return {7'h4D, 7'h41, 7'h52};  // MAR
      3'd2:    return {7'h4D, 7'h49, 7'h45};  // MIE
      3'd3:    return {7'h4A, 7'h55, 7'h45};  // JUE
      3'd4:    return {7'h56, 7'h49, 7'h45};  // VIE
      3'd5:    return {7'h53, 7'h41, 7'h42};  // SAB
      3'd6:    return {7'h44, 7'h4F, 7'h4D};  // DOM
      default: return {7'h2D, 7'h2D, 7'h2D};  // ---
    endcase
  endfunction

  // Frame snapshot: the whole bundle is captured together on frame_tick so
  // the renderer sees one coherent frame. A request in the tick cycle reads
  // these registers before they update, i.e. the previous frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 18; i++) begin
        snap_dig[i] <= 4'd0;
      end
      snap_ampm <= 1'b0;
      snap_dia  <= 3'd0;
      snap_fun  <= 2'd0;
      snap_cur  <= 2'd0;
    end else if (frame_tick) begin
      for (int i = 0; i < 18; i++) begin
        snap_dig[i] <= live_dig[i];
      end
      snap_ampm <= AM_PM;
      snap_dia  <= dia_semana;
      snap_fun  <= funcion;
      snap_cur  <= cursor_location;
    end
  end

  // Cursor blink: every BLINK_FRAMES frames the highlight flips between
  // visible and hidden. It starts visible out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_tick) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign slot     = char_idx[5:0];
  assign in_range = (char_idx < IDX_W'(33));

  // Slot decoder: turns the requested slot into its ASCII code using only
  // snapshot values.
  always_comb begin
    slot_code = CH_SPACE;
    day_chars = day_name(snap_dia);
    if (in_range) begin
      case (slot)
        6'd0:    slot_code = bcd_char(snap_dig[0]);
        6'd1:    slot_code = bcd_char(snap_dig[1]);
        6'd2:    slot_code = CH_COLON;
        6'd3:    slot_code = bcd_char(snap_dig[2]);
        6'd4:    slot_code = bcd_char(snap_dig[3]);
        6'd5:    slot_code = CH_COLON;
        6'd6:    slot_code = bcd_char(snap_dig[4]);
        6'd7:    slot_code = bcd_char(snap_dig[5]);
        6'd9:    slot_code = snap_ampm ? 7'h50 : 7'h41;
        6'd10:   slot_code = 7'h4D;
        6'd12:   slot_code = bcd_char(snap_dig[6]);
        6'd13:   slot_code = bcd_char(snap_dig[7]);
        6'd14:   slot_code = CH_SLASH;
        6'd15:   slot_code = bcd_char(snap_dig[8]);
        6'd16:   slot_code = bcd_char(snap_dig[9]);
        6'd17:   slot_code = CH_SLASH;
        6'd18:   slot_code = bcd_char(snap_dig[10]);
        6'd19:   slot_code = bcd_char(snap_dig[11]);
        6'd21:   slot_code = day_chars[20:14];
        6'd22:   slot_code = day_chars[13:7];
        6'd23:   slot_code = day_chars[6:0];
        6'd25:   slot_code = bcd_char(snap_dig[12]);
        6'd26:   slot_code = bcd_char(snap_dig[13]);
        6'd27:   slot_code = CH_COLON;
        6'd28:   slot_code = bcd_char(snap_dig[14]);
        6'd29:   slot_code = bcd_char(snap_dig[15]);
        6'd30:   slot_code = CH_COLON;
        6'd31:   slot_code = bcd_char(snap_dig[16]);
        6'd32:   slot_code = bcd_char(snap_dig[17]);
        default: slot_code = CH_SPACE;
      endcase
    end
  end

  // Highlight window: funcion picks the group (time, date, timer) and the
  // cursor picks the pair inside it; each pair is three slots after the
  // previous one because of the separator between them. Cursor code 11
  // means no field is under edit.
  always_comb begin
    group_base = 6'd0;
    pair_off   = 6'd6;
    hl_enable  = blink_on && (snap_fun != 2'b00) && (snap_cur != 2'b11);
    case (snap_fun)
      2'b01:   group_base = 6'd0;
      2'b10:   group_base = 6'd12;
      2'b11:   group_base = 6'd25;
      default: group_base = 6'd0;
    endcase
    case (snap_cur)
      2'b10:   pair_off = 6'd0;
      2'b01:   pair_off = 6'd3;
      default: pair_off = 6'd6;
    endcase
    hl_first = group_base + pair_off;
    slot_hl  = hl_enable && in_range &&
               ((slot == hl_first) || (slot == hl_first + 6'd1));
  end

  // Response register: one response per request, one cycle later. Without a
  // request the strobe drops but the last code and highlight stay put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_valid <= 1'b0;
      char_code  <= CH_SPACE;
      char_hl    <= 1'b0;
    end else begin
      char_valid <= char_req;
      if (char_req) begin
        char_code <= slot_code;
        char_hl   <= slot_hl;
      end
    end
  end

endmodule

// File: tb/tb_frame_char_reader.sv
// ---------------------------------------------------------------------------
// tb_frame_char_reader
//
// Purpose:
//   Self-checking bench for frame_char_reader. A table of directed vectors
//   covers the documented scenarios, a few hand-written sequences cover the
//   snapshot timing and reset corners, and a randomized run is checked
//   against a string-based model of the screen line.
// ---------------------------------------------------------------------------
module tb_frame_char_reader;

  localparam int BLINK = 2;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       dig [18];
  logic             am_pm;
  logic [2:0]       dia;
  logic [1:0]       fun;
  logic [1:0]       cur;
  logic             frame_tick;
  logic             char_req;
  logic [IDX_W-1:0] char_idx;
  logic             char_valid;
  logic [6:0]       char_code;
  logic             char_hl;

  int n_cmp;
  int n_fail;

  // Model state: the snapshot the DUT should be showing and the response
  // it should currently be presenting.
  logic [3:0] m_dig [18];
  logic       m_ampm;
  logic [2:0] m_dia;
  logic [1:0] m_fun;
  logic [1:0] m_cur;
  int         m_ticks;
  logic       m_valid;
  logic [6:0] m_code;
  logic       m_hl;

  typedef struct {
    string      name;
    bit         req;
    int         idx;
    bit         tick;
    bit         ev;
    logic [6:0] ec;
    bit         eh;
  } vec_t;

  vec_t vecs[$];

  frame_char_reader #(
    .BLINK_FRAMES(BLINK),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digit1_HH(dig[0]),   .digit0_HH(dig[1]),
    .digit1_MM(dig[2]),   .digit0_MM(dig[3]),
    .digit1_SS(dig[4]),   .digit0_SS(dig[5]),
    .digit1_DAY(dig[6]),  .digit0_DAY(dig[7]),
    .digit1_MES(dig[8]),  .digit0_MES(dig[9]),
    .digit1_YEAR(dig[10]), .digit0_YEAR(dig[11]),
    .digit1_HH_T(dig[12]), .digit0_HH_T(dig[13]),
    .digit1_MM_T(dig[14]), .digit0_MM_T(dig[15]),
    .digit1_SS_T(dig[16]), .digit0_SS_T(dig[17]),
    .AM_PM(am_pm),
    .dia_semana(dia),
    .funcion(fun),
    .cursor_location(cur),
    .frame_tick(frame_tick),
    .char_req(char_req),
    .char_idx(char_idx),
    .char_valid(char_valid),
    .char_code(char_code),
    .char_hl(char_hl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic string bcd_str(input logic [3:0] v);
    if (v > 4'd9) return "?";
    return $sformatf("%0d", v);
  endfunction

  function automatic string pair_str(input int i);
    return {bcd_str(m_dig[i]), bcd_str(m_dig[i + 1])};
  endfunction

  function automatic string day_str(input logic [2:0] d);
    case (d)
      3'd0: return "LUN";
      3'd1: return "MAR";
      3'd2: return "MIE";
      3'd3: return "JUE";
      3'd4: return "VIE";
      3'd5: return "SAB";
      3'd6: return "DOM";
      default: return "---";
    endcase
  endfunction

  // The full 33-character line as it should appear on screen.
  function automatic string render();
    return {pair_str(0), ":", pair_str(2), ":", pair_str(4), " ",
            (m_ampm ? "PM" : "AM"), " ",
            pair_str(6), "/", pair_str(8), "/", pair_str(10), " ",
            day_str(m_dia), " ",
            pair_str(12), ":", pair_str(14), ":", pair_str(16)};
  endfunction

  function automatic logic model_hl(input int idx);
    int group_start;
    int pair;
    int start;
    bit blink;
    if (m_fun == 2'b00 || m_cur == 2'b11) return 1'b0;
    blink = ((m_ticks / BLINK) % 2) == 0;
    if (!blink) return 1'b0;
    group_start = (m_fun == 2'b01) ? 0 : (m_fun == 2'b10) ? 12 : 25;
    pair = (m_cur == 2'b10) ? 0 : (m_cur == 2'b01) ? 1 : 2;
    start = group_start + 3 * pair;
    return (idx == start) || (idx == start + 1);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 18; i++) m_dig[i] = 4'd0;
    m_ampm  = 1'b0;
    m_dia   = 3'd0;
    m_fun   = 2'd0;
    m_cur   = 2'd0;
    m_ticks = 0;
    m_valid = 1'b0;
    m_code  = 7'h20;
    m_hl    = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, and leave the bench
  // 1 time unit after the clock edge where the response can be sampled.
  task automatic applyStimulus(input bit req, input int idx, input bit tick);
    string      line;
    logic [7:0] c;
    char_req   = req;
    char_idx   = idx[IDX_W-1:0];
    frame_tick = tick;
    if (req) begin
      line = render();
      if (idx < 33) c = line[idx];
      else          c = 8'h20;
      m_code  = c[6:0];
      m_hl    = model_hl(idx);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (tick) begin
      for (int i = 0; i < 18; i++) m_dig[i] = dig[i];
      m_ampm = am_pm;
      m_dia  = dia;
      m_fun  = fun;
      m_cur  = cur;
      m_ticks++;
    end
    @(posedge clk);
    #1;
    char_req   = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic checkOutput(input string name, input bit ev, input logic [6:0] ec, input bit eh);
    n_cmp++;
    if (char_valid !== ev || char_code !== ec || char_hl !== eh) begin
      n_fail++;
      $display("[TB] FAIL %s: got valid=%0b code=0x%02h hl=%0b, expected valid=%0b code=0x%02h hl=%0b",
               name, char_valid, char_code, char_hl, ev, ec, eh);
    end
  endtask

  task automatic addVec(input string name, input bit req, input int idx, input bit tick,
                        input bit ev, input logic [6:0] ec, input bit eh);
    vec_t v;
    v.name = name; v.req = req; v.idx = idx; v.tick = tick;
    v.ev = ev; v.ec = ec; v.eh = eh;
    vecs.push_back(v);
  endtask

  initial begin
    bit tick;
    bit req;
    int idx;

    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 18; i++) dig[i] = 4'd0;
    am_pm = 1'b0; dia = 3'd0; fun = 2'd0; cur = 2'd0;
    frame_tick = 1'b0; char_idx = '0;
    char_req = 1'b1;
    modelReset();

    // Directed vectors, run after the bundle below is loaded with one tick:
    // HH=15 MM=52 SS=39 DAY=28 MES=02 YEAR=2C TIMER=01:23:45, PM, VIE,
    // funcion=10 (date), cursor=01 (MES highlighted), blink visible.
    addVec("hh_tens",    1, 0,  0, 1, 7'h31, 0);
    addVec("hh_units",   1, 1,  0, 1, 7'h35, 0);
    addVec("mm_tens",    1, 3,  0, 1, 7'h35, 0);
    addVec("ss_units",   1, 7,  0, 1, 7'h39, 0);
    addVec("mes_hl0",    1, 15, 0, 1, 7'h30, 1);
    addVec("mes_hl1",    1, 16, 0, 1, 7'h32, 1);
    addVec("day_nohl",   1, 12, 0, 1, 7'h32, 0);
    addVec("year_tens",  1, 18, 0, 1, 7'h32, 0);
    addVec("year_bad",   1, 19, 0, 1, 7'h3F, 0);
    addVec("idx40",      1, 40, 0, 1, 7'h20, 0);
    addVec("idx33",      1, 33, 0, 1, 7'h20, 0);
    addVec("colon2",     1, 2,  0, 1, 7'h3A, 0);
    addVec("slash14",    1, 14, 0, 1, 7'h2F, 0);
    addVec("day_V",      1, 21, 0, 1, 7'h56, 0);
    addVec("day_I",      1, 22, 0, 1, 7'h49, 0);
    addVec("day_E",      1, 23, 0, 1, 7'h45, 0);
    addVec("pm_P",       1, 9,  0, 1, 7'h50, 0);
    addVec("pm_M",       1, 10, 0, 1, 7'h4D, 0);
    addVec("idle_hold",  0, 0,  0, 0, 7'h4D, 0);
    addVec("tmr_hh_t",   1, 25, 0, 1, 7'h30, 0);
    addVec("tmr_hh_u",   1, 26, 0, 1, 7'h31, 0);
    addVec("tmr_ss_u",   1, 32, 0, 1, 7'h35, 0);
    addVec("tick_old",   1, 15, 1, 1, 7'h30, 1);
    addVec("blink_off0", 1, 15, 0, 1, 7'h30, 0);
    addVec("blink_off1", 1, 16, 0, 1, 7'h32, 0);
    addVec("day_off",    1, 12, 0, 1, 7'h32, 0);
    addVec("tick3_idle", 0, 0,  1, 0, 7'h32, 0);
    addVec("tick4_idle", 0, 0,  1, 0, 7'h32, 0);
    addVec("blink_on",   1, 15, 0, 1, 7'h30, 1);
    addVec("day_on",     1, 12, 0, 1, 7'h32, 0);

    // Reset state, with a request pending while reset is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 0, 7'h20, 0);
    char_req = 1'b0;
    reset    = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("post_reset_idle", 0, 7'h20, 0);

    // Load the bundle.
    dig[0] = 4'd1; dig[1] = 4'd5; dig[2] = 4'd5; dig[3] = 4'd2; dig[4] = 4'd3; dig[5] = 4'd9;
    dig[6] = 4'd2; dig[7] = 4'd8; dig[8] = 4'd0; dig[9] = 4'd2; dig[10] = 4'd2; dig[11] = 4'hC;
    dig[12] = 4'd0; dig[13] = 4'd1; dig[14] = 4'd2; dig[15] = 4'd3; dig[16] = 4'd4; dig[17] = 4'd5;
    am_pm = 1'b1; dia = 3'd4; fun = 2'b10; cur = 2'b01;
    applyStimulus(0, 0, 1);
    checkOutput("load_tick", 0, 7'h20, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].idx, vecs[i].tick);
      checkOutput(vecs[i].name, vecs[i].ev, vecs[i].ec, vecs[i].eh);
    end

    // Live input change is invisible until the next frame tick, and a
    // request in the tick cycle still sees the old value.
    dig[1] = 4'd7;
    applyStimulus(1, 1, 0);
    checkOutput("no_tick_old", 1, 7'h35, 0);
    applyStimulus(1, 1, 1);
    checkOutput("same_cycle_tick", 1, 7'h35, 0);
    applyStimulus(1, 1, 0);
    checkOutput("after_tick_new", 1, 7'h37, 0);

    // Invalid weekday.
    dia = 3'd7;
    applyStimulus(0, 0, 1);
    checkOutput("dia7_tick", 0, 7'h37, 0);
    applyStimulus(1, 21, 0);
    checkOutput("dia7_c0", 1, 7'h2D, 0);
    applyStimulus(1, 22, 0);
    checkOutput("dia7_c1", 1, 7'h2D, 0);
    applyStimulus(1, 23, 0);
    checkOutput("dia7_c2", 1, 7'h2D, 0);

    // Reset asserted in the middle of a request.
    char_req = 1'b1;
    char_idx = 6'd0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("reset_async", 0, 7'h20, 0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 0, 7'h20, 0);
    char_req = 1'b0;
    reset    = 1'b1;
    modelReset();

    // Randomized traffic against the line model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < 18; k++) dig[k] = 4'($urandom_range(0, 11));
        am_pm = 1'($urandom_range(0, 1));
        dia   = 3'($urandom_range(0, 7));
        fun   = 2'($urandom_range(0, 3));
        cur   = 2'($urandom_range(0, 3));
      end
      tick = ($urandom_range(0, 5) == 0);
      req  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(33, 63));
      else                           idx = int'($urandom_range(0, 32));
      applyStimulus(req, idx, tick);
      checkOutput("random", m_valid, m_code, m_hl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
